spi_master_tx: RTL and testbench

SPI master transmitter (mode 0: CPOL=0, CPHA=0, MSB first) that drives SCK, CS and MOSI toward the DF2 SPI slave receiver and samples MISO for full-duplex use. It generates SCK from the system clock with a programmable half-period. CS is held high for a guard interval after every frame, so a slave with a 2-flop input synchronizer sees CS deassert and returns to idle. The block sits in the same clock domain as the slave-side logic and is driven by a simple start/busy/done handshake.

---
 rtl/spi_master_tx.sv | 192 +++++++++++++++++++
 tb/tb_spi_master_tx.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_tx.sv
// SPI mode-0 master (CPOL=0, CPHA=0, MSB first) with programmable SCK half-period.
// CS is held high for a guard interval after every frame so a synchronized slave can see it deassert.
module spi_master_tx #(
  parameter int N       = 8,
  parameter int CLK_DIV = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] data_in,
  input  logic         MISO,
  output logic         SCK,
  output logic         MOSI,
  output logic         CS,
  output logic [N-1:0] data_out,
  output logic         busy,
  output logic         done
);

  localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_N    = CNT_W'(N);

  // A 2-flop slave synchronizer needs at least two clk cycles per SCK phase.
  generate
    if (CLK_DIV < 2) begin : g_bad_div
      $error("spi_master_tx: CLK_DIV must be >= 2");
    end
    if (N < 2) begin : g_bad_n
      $error("spi_master_tx: N must be >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   bit_q, bit_d;
  logic [N-1:0]       tx_q, tx_d;
  logic [N-1:0]       rx_q, rx_d;
  logic [N-1:0]       dout_q, dout_d;
  logic               sck_q, sck_d;
  logic               mosi_q, mosi_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_wrap;

  assign div_wrap = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // MSB goes out immediately; the register keeps the remaining bits left-aligned.
          tx_d    = {data_in[N-2:0], 1'b0};
          mosi_d  = data_in[N-1];
          rx_d    = '0;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
          state_d = SETUP;
        end
      end

      SETUP: begin
        if (div_wrap) begin
          div_d   = '0;
          sck_d   = 1'b1;
          rx_d    = {rx_q[N-2:0], MISO};
          bit_d   = bit_q + 1'b1;
          state_d = SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      SHIFT: begin
        if (!div_wrap) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (sck_q) begin
            sck_d = 1'b0;
            if (bit_q < CNT_N) begin
              mosi_d = tx_q[N-1];
              tx_d   = {tx_q[N-2:0], 1'b0};
            end else begin
              mosi_d = 1'b0;
            end
          end else if (bit_q == CNT_N) begin
            // Last low phase has completed; SCK stays low through HOLD.
            bit_d   = '0;
            state_d = HOLD;
          end else begin
            sck_d = 1'b1;
            rx_d  = {rx_q[N-2:0], MISO};
            bit_d = bit_q + 1'b1;
          end
        end
      end

      HOLD: begin
        if (div_wrap) begin
          div_d   = '0;
          cs_d    = 1'b1;
          dout_d  = rx_q;
          done_d  = 1'b1;
          state_d = GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      GAP: begin
        if (div_wrap) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        sck_d   = 1'b0;
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SCK      = sck_q;
  assign MOSI     = mosi_q;
  assign CS       = cs_q;
  assign data_out = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: vector table of single frames plus hand-written corner sequences
// and a loopback into a slave model with a 2-flop input synchronizer.
module tb_spi_master_tx;
  localparam int N    = 8;
  localparam int DIV  = 4;
  localparam int DIV2 = 2;

  logic         clk     = 1'b0;
  logic         reset   = 1'b0;
  logic         start   = 1'b0;
  logic [N-1:0] data_in = '0;
  logic         miso    = 1'b0;
  logic         sck, mosi, cs, busy, done;
  logic [N-1:0] data_out;

  logic         start2   = 1'b0;
  logic [N-1:0] data_in2 = '0;
  logic         miso2    = 1'b0;
  logic         sck2, mosi2, cs2, busy2, done2;
  logic [N-1:0] data_out2;

  always #5 clk = ~clk;

  spi_master_tx #(.N(N), .CLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .MISO(miso),
    .SCK(sck), .MOSI(mosi), .CS(cs), .data_out(data_out), .busy(busy), .done(done)
  );

  spi_master_tx #(.N(N), .CLK_DIV(DIV2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .data_in(data_in2), .MISO(miso2),
    .SCK(sck2), .MOSI(mosi2), .CS(cs2), .data_out(data_out2), .busy(busy2), .done(done2)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor and MISO responder for dut (all sampled on the falling clk edge)
  int           cyc = 0;
  logic         mon_clr = 1'b0;
  logic         sck_p = 1'b0, cs_p = 1'b1, busy_p = 1'b0;
  int           rises = 0, dones = 0, cs_falls = 0, busy_rises = 0, busy_falls = 0;
  int           cs_fall_cyc = -1, done_cyc = -1, busy_fall_cyc = -1, bf_to_cs = -1;
  int           cs_hi_run = 0, min_cs_hi = 1000;
  logic [N-1:0] mosi_sh = '0;
  logic [N-1:0] mosi_frames[$];
  logic [N-1:0] rx_frames[$];
  logic [N-1:0] miso_word = '0;
  int           miso_idx = -1;

  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      rises = 0; dones = 0; cs_falls = 0; busy_rises = 0; busy_falls = 0;
      cs_fall_cyc = -1; done_cyc = -1; busy_fall_cyc = -1; bf_to_cs = -1;
      cs_hi_run = 0; min_cs_hi = 1000; mosi_sh = '0;
      mosi_frames.delete(); rx_frames.delete();
    end else begin
      if (sck && !sck_p) begin
        rises++;
        mosi_sh = {mosi_sh[N-2:0], mosi};
      end
      if (!cs && cs_p) begin
        cs_falls++;
        if (cs_fall_cyc < 0) cs_fall_cyc = cyc;
        if (cs_falls > 1 && cs_hi_run < min_cs_hi) min_cs_hi = cs_hi_run;
        if (busy_fall_cyc >= 0) bf_to_cs = cyc - busy_fall_cyc;
      end
      cs_hi_run = cs ? cs_hi_run + 1 : 0;
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        mosi_frames.push_back(mosi_sh);
        rx_frames.push_back(data_out);
      end
      if (busy && !busy_p) busy_rises++;
      if (!busy && busy_p) begin
        busy_falls++;
        busy_fall_cyc = cyc;
      end
    end
    if (!cs && cs_p) begin
      miso = miso_word[N-1];
      miso_idx = N - 2;
    end else if (!sck && sck_p && miso_idx >= 0) begin
      miso = miso_word[miso_idx];
      miso_idx--;
    end
    sck_p = sck; cs_p = cs; busy_p = busy;
  end

  // Slave model for dut2: 2-flop synchronizers, samples MOSI on synchronized SCK rise
  logic [1:0] s_sck_s = 2'b00, s_cs_s = 2'b11, s_mosi_s = 2'b00;
  logic       s_sck_d = 1'b0;
  logic [3:0] s_cnt = '0;
  logic [7:0] s_sh = '0, s_data = '0;
  int         s_dones = 0;
  time        s_done_t = 0;

  always @(posedge clk) begin
    s_sck_s  <= {s_sck_s[0], sck2};
    s_cs_s   <= {s_cs_s[0], cs2};
    s_mosi_s <= {s_mosi_s[0], mosi2};
    s_sck_d  <= s_sck_s[1];
    if (s_cs_s[1]) begin
      s_cnt <= '0;
    end else if (s_sck_s[1] && !s_sck_d) begin
      s_sh <= {s_sh[6:0], s_mosi_s[1]};
      if (s_cnt == 4'd7) begin
        s_data <= {s_sh[6:0], s_mosi_s[1]};
        s_dones++;
        s_done_t = $time;
        s_cnt <= '0;
      end else begin
        s_cnt <= s_cnt + 4'd1;
      end
    end
  end

  logic sck2_p = 1'b0, cs2_p = 1'b1, busy2_p = 1'b0;
  int   rises2 = 0, dones2 = 0;
  time  cs2_rise_t = 0;
  logic s_idle_at_bf = 1'b0;

  always @(negedge clk) begin
    if (sck2 && !sck2_p) rises2++;
    if (cs2 && !cs2_p) cs2_rise_t = $time;
    if (done2) dones2++;
    if (!busy2 && busy2_p) s_idle_at_bf = s_cs_s[1];
    sck2_p = sck2; cs2_p = cs2; busy2_p = busy2;
  end

  task automatic clr_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] d);
    @(negedge clk); start = 1'b1; data_in = d;
    @(negedge clk); start = 1'b0; data_in = ~d;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 2000) begin @(negedge clk); k++; end
    chk({name, " idle timeout"}, (k < 2000), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_rises(input int n, input string name);
    int k = 0;
    while (rises < n && k < 2000) begin @(negedge clk); k++; end
    chk({name, " rise timeout"}, (k < 2000), 1);
  endtask

  typedef struct {
    logic [N-1:0] din;
    logic [N-1:0] miso_w;
    logic [N-1:0] exp_mosi;
    logic [N-1:0] exp_rx;
    int           exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C, 72};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF, 72};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 72};
    vecs[3] = '{8'h96, 8'h69, 8'h96, 8'h69, 72};

    // Reset state, asserted away from any clock edge
    #1 reset = 1'b1;
    #1 chk("reset_state", {sck, cs, mosi, busy, done, data_out}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_state_dut2", {sck2, cs2, mosi2, busy2, done2}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < 4; i++) begin
      clr_mon();
      miso_word = vecs[i].miso_w;
      send(vecs[i].din);
      wait_idle("vec");
      chk("vec_rises", rises, 8);
      chk("vec_dones", dones, 1);
      chk("vec_mosi", mosi_frames.size() > 0 ? mosi_frames[0] : 8'hxx, vecs[i].exp_mosi);
      chk("vec_data_out", data_out, vecs[i].exp_rx);
      chk("vec_done_latency", done_cyc - cs_fall_cyc, vecs[i].exp_lat);
    end

    // Reset in idle clears the held data_out asynchronously
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("reset_idle", {sck, cs, mosi, busy, done, data_out}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk); reset = 1'b0;

    // Abort after 3 rising edges, then a clean frame
    clr_mon();
    miso_word = 8'hF0;
    send(8'hA5);
    wait_rises(3, "abort");
    #2 reset = 1'b1;
    #1 chk("reset_mid_frame", {sck, cs, mosi, busy, done, data_out}, {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort_no_done", dones, 0);
    clr_mon();
    miso_word = 8'h55;
    send(8'h0F);
    wait_idle("after_abort");
    chk("after_abort_rises", rises, 8);
    chk("after_abort_mosi", mosi_frames.size() > 0 ? mosi_frames[0] : 8'hxx, 8'h0F);
    chk("after_abort_dones", dones, 1);
    chk("after_abort_data_out", data_out, 8'h55);

    // Start pulse while busy is ignored
    clr_mon();
    miso_word = 8'h3C;
    send(8'hA5);
    wait_rises(3, "busy_prot");
    @(negedge clk); start = 1'b1; data_in = 8'hFF;
    @(negedge clk); start = 1'b0;
    wait_idle("busy_prot");
    repeat (20) @(negedge clk);
    chk("busy_prot_dones", dones, 1);
    chk("busy_prot_cs_falls", cs_falls, 1);
    chk("busy_prot_mosi", mosi_frames.size() > 0 ? mosi_frames[0] : 8'hxx, 8'hA5);
    chk("busy_prot_busy_rises", busy_rises, 1);
    chk("busy_prot_busy_falls", busy_falls, 1);
    chk("busy_prot_data_out", data_out, 8'h3C);

    // Back-to-back with start held high
    clr_mon();
    miso_word = 8'hC3;
    @(negedge clk); start = 1'b1; data_in = 8'h81;
    @(negedge clk); data_in = 8'h7E;
    begin
      int k = 0;
      while (cs_falls < 2 && k < 2000) begin @(negedge clk); k++; end
      chk("b2b second frame timeout", (k < 2000), 1);
    end
    start = 1'b0;
    wait_idle("b2b");
    chk("b2b_dones", dones, 2);
    chk("b2b_mosi0", mosi_frames.size() > 0 ? mosi_frames[0] : 8'hxx, 8'h81);
    chk("b2b_mosi1", mosi_frames.size() > 1 ? mosi_frames[1] : 8'hxx, 8'h7E);
    chk("b2b_rx1", rx_frames.size() > 1 ? rx_frames[1] : 8'hxx, 8'hC3);
    chk("b2b_cs_gap_ge5", (min_cs_hi >= 5 && min_cs_hi < 1000), 1);
    chk("b2b_busy_to_cs", bf_to_cs, 1);

    // Loopback into synchronized slave, CLK_DIV=2
    @(negedge clk); start2 = 1'b1; data_in2 = 8'h5A;
    @(negedge clk); start2 = 1'b0; data_in2 = 8'h00;
    begin
      int k = 0;
      while (busy2 && k < 2000) begin @(negedge clk); k++; end
      chk("loop idle timeout", (k < 2000), 1);
    end
    repeat (4) @(negedge clk);
    chk("loop_slave_data", s_data, 8'h5A);
    chk("loop_slave_dones", s_dones, 1);
    chk("loop_slave_done_before_cs", (s_done_t > 0 && s_done_t < cs2_rise_t), 1);
    chk("loop_slave_idle_in_gap", s_idle_at_bf, 1'b1);
    chk("loop_rises", rises2, 8);
    chk("loop_master_dones", dones2, 1);
    chk("loop_master_rx", data_out2, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
